// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES datapath types and GF(2^8) helpers (polynomial x^8+x^4+x^3+x+1).
//   byte_t  : one state byte
//   col_t   : one state column, element r is row r
//   xtime / gf_mulN : constant multipliers used by the MixColumns networks
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam logic [7:0] GF_RED = 8'h1B;

    typedef logic [7:0]  byte_t;
    typedef byte_t [3:0] col_t;

    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_RED : 8'h00);
    endfunction

    function automatic byte_t gf_mul2(input byte_t a);
        return xtime(a);
    endfunction

    function automatic byte_t gf_mul3(input byte_t a);
        return xtime(a) ^ a;
    endfunction

    // The inverse multipliers share the x2/x4/x8 chain.
    function automatic byte_t gf_mul9(input byte_t a);
        byte_t m2, m4, m8;
        m2 = xtime(a);
        m4 = xtime(m2);
        m8 = xtime(m4);
        return m8 ^ a;
    endfunction

    function automatic byte_t gf_mul11(input byte_t a);
        byte_t m2, m4, m8;
        m2 = xtime(a);
        m4 = xtime(m2);
        m8 = xtime(m4);
        return m8 ^ m2 ^ a;
    endfunction

    function automatic byte_t gf_mul13(input byte_t a);
        byte_t m2, m4, m8;
        m2 = xtime(a);
        m4 = xtime(m2);
        m8 = xtime(m4);
        return m8 ^ m4 ^ a;
    endfunction

    function automatic byte_t gf_mul14(input byte_t a);
        byte_t m2, m4, m8;
        m2 = xtime(a);
        m4 = xtime(m2);
        m8 = xtime(m4);
        return m8 ^ m4 ^ m2;
    endfunction

endpackage

// File: rtl/mix_column_core.sv
// -----------------------------------------------------------------------------
// mix_column_core
// Purely combinational MixColumns network for one column.
//   a    : input column (row r in a[r])
//   mode : 0 = forward MixColumns, 1 = InvMixColumns
//   o    : transformed column
// Build option: MIX_COLUMN_INV_EN adds the inverse network; without it the
// block is forward-only and mode is ignored.
// -----------------------------------------------------------------------------
module mix_column_core
    import aes_pkg::*;
(
    input  col_t a,
    input  logic mode,
    output col_t o
);

    col_t fwd;

    for (genvar r = 0; r < 4; r++) begin : g_fwd
        localparam int R1 = (r + 1) % 4;
        localparam int R2 = (r + 2) % 4;
        localparam int R3 = (r + 3) % 4;
        assign fwd[r] = gf_mul2(a[r]) ^ gf_mul3(a[R1]) ^ a[R2] ^ a[R3];
    end

`ifdef MIX_COLUMN_INV_EN
    col_t inv_col;

    for (genvar r = 0; r < 4; r++) begin : g_inv
        localparam int R1 = (r + 1) % 4;
        localparam int R2 = (r + 2) % 4;
        localparam int R3 = (r + 3) % 4;
        assign inv_col[r] = gf_mul14(a[r]) ^ gf_mul11(a[R1]) ^
                            gf_mul13(a[R2]) ^ gf_mul9(a[R3]);
    end

    assign o = mode ? inv_col : fwd;
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign o = fwd;
`endif

endmodule

// File: rtl/mix_column_stream.sv
// -----------------------------------------------------------------------------
// mix_column_stream
// Byte-lane-serial MixColumns stage. Collects one 32-bit column over
// 4/IN_BYTES beats, transforms it, and holds the result as four bytes.
//   clk, rst         : clock, asynchronous active-high reset
//   clr              : synchronous clear of the partially collected column
//   inv              : mode for the column, sampled on its first beat
//   in_valid/ready   : input beat handshake, d_in lane k = row beat*IN_BYTES+k
//   out_valid/ready  : output column handshake
//   d0_out..d3_out   : result rows 0..3
// Build option: MIX_COLUMN_INV_EN enables the inverse (decrypt) mode.
// -----------------------------------------------------------------------------
module mix_column_stream
    import aes_pkg::*;
#(
    parameter int IN_BYTES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  inv,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*IN_BYTES-1:0] d_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            d0_out,
    output logic [7:0]            d1_out,
    output logic [7:0]            d2_out,
    output logic [7:0]            d3_out
);

    if (!(IN_BYTES == 1 || IN_BYTES == 2 || IN_BYTES == 4)) begin : g_bad_in_bytes
        $error("mix_column_stream: IN_BYTES must be 1, 2 or 4");
    end

    localparam int         BEATS     = 4 / IN_BYTES;
    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    logic [1:0] cnt_q, cnt_d;
    col_t       col_q, col_d;
    logic       out_valid_q, out_valid_d;
    col_t       dout_q, dout_d;

    logic       last_beat;
    logic       accept;
    logic       load;
    logic       col_mode;
    col_t       full_col;
    col_t       result;
    logic [1:0] row;

    assign last_beat = (cnt_q == LAST_BEAT);
    // The last beat may only enter when the output slot is empty or being drained.
    assign in_ready  = !clr && (!last_beat || !out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign load      = accept && last_beat;

    // Collected bytes with the current beat's lanes merged in; on the last
    // beat this is the complete column fed to the network.
    always_comb begin
        full_col = col_q;
        row      = 2'd0;
        for (int k = 0; k < IN_BYTES; k++) begin
            row           = 2'(int'(cnt_q) * IN_BYTES + k);
            full_col[row] = d_in[8*k +: 8];
        end
    end

`ifdef MIX_COLUMN_INV_EN
    logic mode_q, mode_d;

    always_comb begin
        mode_d = mode_q;
        if (accept && cnt_q == 2'd0) begin
            mode_d = inv;
        end
    end

    // Single-beat columns have no earlier beat to capture the mode from.
    assign col_mode = (BEATS == 1) ? inv : mode_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
        end
    end
`else
    logic unused_inv;
    assign unused_inv = inv;
    assign col_mode   = 1'b0;
`endif

    mix_column_core u_core (
        .a    (full_col),
        .mode (col_mode),
        .o    (result)
    );

    always_comb begin
        cnt_d = cnt_q;
        col_d = col_q;
        if (clr) begin
            cnt_d = 2'd0;
        end else if (accept) begin
            if (last_beat) begin
                cnt_d = 2'd0;
            end else begin
                cnt_d = cnt_q + 2'd1;
                col_d = full_col;
            end
        end
    end

    // A load in the same cycle as a handshake keeps out_valid high.
    always_comb begin
        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        if (load) begin
            out_valid_d = 1'b1;
            dout_d      = result;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= 2'd0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
        end else begin
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
        end
    end

    assign out_valid = out_valid_q;
    assign d0_out    = dout_q[0];
    assign d1_out    = dout_q[1];
    assign d2_out    = dout_q[2];
    assign d3_out    = dout_q[3];

endmodule

// File: tb/tb_mix_column_stream.sv
// -----------------------------------------------------------------------------
// tb_mix_column_stream
// Drives three instances (IN_BYTES = 1, 2, 4) against a column-level
// reference model using generic GF(2^8) multiplication.
// -----------------------------------------------------------------------------
module tb_mix_column_stream;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        v     [3];
    logic        ordy  [3];
    logic        clr_s [3];
    logic        inv_s [3];
    logic [31:0] bus   [3];
    logic        ir    [3];
    logic        ov    [3];
    logic [7:0]  dq    [3][4];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_column_stream #(.IN_BYTES(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr_s[g]),
            .inv       (inv_s[g]),
            .in_valid  (v[g]),
            .in_ready  (ir[g]),
            .d_in      (bus[g][8*(1<<g)-1:0]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .d0_out    (dq[g][0]),
            .d1_out    (dq[g][1]),
            .d2_out    (dq[g][2]),
            .d3_out    (dq[g][3])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, per instance
    logic [7:0]  part  [3][4];
    int          pcnt  [3];
    logic        pmode [3];
    logic        expv  [3];
    logic [31:0] expc  [3];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int ib(input int d);
        return 1 << d;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int p = 0;
        int x = int'(a);
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x << 1;
            if ((x & 'h100) != 0) x = x ^ 'h11B;
        end
        return 8'(p);
    endfunction

    function automatic logic [31:0] ref_mix(input logic [31:0] col, input logic im);
        logic [7:0]  cf [4];
        logic [31:0] res = '0;
        logic [7:0]  acc;
        if (im) cf = '{8'd14, 8'd11, 8'd13, 8'd9};
        else    cf = '{8'd2, 8'd3, 8'd1, 8'd1};
        for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) begin
                acc = acc ^ gmul(col[8*j +: 8], cf[(j - r + 4) % 4]);
            end
            res[8*r +: 8] = acc;
        end
        return res;
    endfunction

    function automatic logic [31:0] outw(input int d);
        return {dq[d][3], dq[d][2], dq[d][1], dq[d][0]};
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 3; d++) begin
            pcnt[d]  = 0;
            pmode[d] = 1'b0;
            expv[d]  = 1'b0;
            expc[d]  = '0;
        end
    endtask

    // Inputs are set at the falling edge before calling; one full clock.
    task automatic tick();
        logic acc [3];
        logic hs  [3];
        logic exp_ir;
        logic ld;
        logic im;
        #1;
        for (int d = 0; d < 3; d++) begin
            exp_ir = !clr_s[d] && (pcnt[d] != 4 - ib(d) || !expv[d] || ordy[d]);
            check_eq($sformatf("in_ready[%0d]", d), 32'(ir[d]), 32'(exp_ir));
            check_eq($sformatf("out_valid[%0d]", d), 32'(ov[d]), 32'(expv[d]));
            if (expv[d]) check_eq($sformatf("out_data[%0d]", d), outw(d), expc[d]);
            acc[d] = v[d] && ir[d];
            hs[d]  = ov[d] && ordy[d];
        end
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            ld = 1'b0;
            if (clr_s[d]) begin
                pcnt[d] = 0;
            end else if (acc[d]) begin
                if (pcnt[d] == 0) pmode[d] = inv_s[d];
                for (int k = 0; k < ib(d); k++) part[d][pcnt[d] + k] = bus[d][8*k +: 8];
                pcnt[d] = pcnt[d] + ib(d);
                if (pcnt[d] == 4) begin
                    pcnt[d] = 0;
                    ld = 1'b1;
`ifdef MIX_COLUMN_INV_EN
                    im = pmode[d];
`else
                    im = 1'b0;
`endif
                    expc[d] = ref_mix({part[d][3], part[d][2], part[d][1], part[d][0]}, im);
                end
            end
            if (ld)         expv[d] = 1'b1;
            else if (hs[d]) expv[d] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic beat(input int d, input logic [31:0] val);
        v[d]   = 1'b1;
        bus[d] = val;
        tick();
        v[d]   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("rst_valid[%0d]", d), 32'(ov[d]), 32'd0);
            check_eq($sformatf("rst_data[%0d]", d), outw(d), 32'h0);
        end
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            v[d] = 1'b0; ordy[d] = 1'b1; clr_s[d] = 1'b0; inv_s[d] = 1'b0; bus[d] = '0;
        end
        model_clear();
        @(negedge clk);
        do_reset();
        tick();

        // Single-byte column
        beat(0, 32'hdb); beat(0, 32'h13); beat(0, 32'h53); beat(0, 32'h45);
        check_eq("t1_valid", 32'(ov[0]), 32'd1);
        check_eq("t1_data", outw(0), 32'hbca14d8e);

        // Backpressure: first three beats of the next column enter, the last stalls
        ordy[0] = 1'b0;
        beat(0, 32'hf2); beat(0, 32'h0a); beat(0, 32'h22);
        v[0] = 1'b1; bus[0] = 32'h5c;
        tick(); tick();
        check_eq("bp_stall", 32'(ir[0]), 32'd0);
        check_eq("bp_hold", outw(0), 32'hbca14d8e);
        ordy[0] = 1'b1;
        tick();
        v[0] = 1'b0;
        check_eq("bp_swap_valid", 32'(ov[0]), 32'd1);
        check_eq("bp_swap_data", outw(0), 32'h9d58dc9f);
        tick();

        // Clear drops a partial column
        beat(0, 32'hdb); beat(0, 32'h13);
        clr_s[0] = 1'b1; tick(); clr_s[0] = 1'b0;
        beat(0, 32'hf2); beat(0, 32'h0a); beat(0, 32'h22); beat(0, 32'h5c);
        check_eq("clr_data", outw(0), 32'h9d58dc9f);
        tick();

        // Full-width back-to-back columns
        v[2] = 1'b1; bus[2] = 32'h455313db;
        tick();
        check_eq("w4_first", outw(2), 32'hbca14d8e);
        check_eq("w4_ready", 32'(ir[2]), 32'd1);
        bus[2] = 32'h5c220af2;
        tick();
        v[2] = 1'b0;
        check_eq("w4_second", outw(2), 32'h9d58dc9f);
        tick();

`ifdef MIX_COLUMN_INV_EN
        // Inverse mode, toggled after the first beat
        inv_s[1] = 1'b1; beat(1, 32'h4d8e);
        inv_s[1] = 1'b0; beat(1, 32'hbca1);
        check_eq("inv_data", outw(1), 32'h455313db);
        tick();
`endif

        // Reset with a held column and a partial column pending
        ordy[0] = 1'b0;
        beat(0, 32'hdb); beat(0, 32'h13); beat(0, 32'h53); beat(0, 32'h45);
        beat(0, 32'hf2); beat(0, 32'h0a);
        do_reset();
        ordy[0] = 1'b1;
        tick();
        beat(0, 32'hdb); beat(0, 32'h13); beat(0, 32'h53); beat(0, 32'h45);
        check_eq("post_rst_data", outw(0), 32'hbca14d8e);
        tick();

        // Randomized traffic on all instances
        repeat (1500) begin
            for (int d = 0; d < 3; d++) begin
                v[d]     = 1'($urandom_range(0, 1));
                ordy[d]  = ($urandom_range(0, 3) != 0);
                clr_s[d] = ($urandom_range(0, 15) == 0);
                inv_s[d] = 1'($urandom_range(0, 1));
                bus[d]   = $urandom;
            end
            if ($urandom_range(0, 299) == 0) do_reset();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mix_column_stream.md
# mix_column_stream

Parametrised, byte-lane-serial MixColumns stage for the low-area AES datapath: collects one 32-bit state column over one, two or four input beats, applies forward or (optionally) inverse MixColumns, and presents the resulting column as four parallel bytes. It sits between ShiftRows/SubBytes and AddRoundKey. Compared with the fixed single-byte `en` interface, it adds:
- a configurable input beat width
- valid/ready flow control on both sides
- a one-column skid so input can stream while output is stalled
- a synchronous partial-column clear
- an optional inverse mode for decryption

## Interface
Parameters:
- IN_BYTES, default 1: bytes accepted per input beat; legal values 1, 2, 4; anything else is a compile-time error.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear of the partially collected column; the output stage is untouched.
- inv  input  1  mode, 0 = forward MixColumns, 1 = InvMixColumns; sampled on the first beat of each column.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat accepted this cycle when both in_valid and in_ready are high.
- d_in  input  8*IN_BYTES  column bytes; lane k (d_in[8k+7:8k]) is row (beat_index*IN_BYTES + k).
- out_valid  output  1  d0_out..d3_out hold a finished column.
- out_ready  input  1  consumer takes the column when out_valid and out_ready are both high.
- d0_out, d1_out, d2_out, d3_out  output  8 each  result rows 0..3.

## Operation
- BEATS = 4/IN_BYTES. A beat counter cnt runs 0..BEATS-1 and increments on each accepted beat, wrapping to 0 after the last beat.
- Non-last beats (cnt < BEATS-1) are written into a collection register; for these, in_ready = 1 unconditionally.
- The last beat is accepted only when the output slot is free or draining: in_ready = !out_valid || out_ready.
- When the last beat is accepted, the result is computed combinationally from the collection register plus d_in and registered into the output stage; out_valid is then set.
- mode_q is captured from inv when cnt == 0 and a beat is accepted. Changes to inv mid-column are ignored. With BEATS == 1, inv is used directly.
- Arithmetic is GF(2^8) with polynomial 0x11B; xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1B : 0). For row r, with indices mod 4:
  - forward: o_r = 2·a_r ^ 3·a_(r+1) ^ a_(r+2) ^ a_(r+3).
  - inverse: o_r = 14·a_r ^ 11·a_(r+1) ^ 13·a_(r+2) ^ 9·a_(r+3).
- Output stage: out_valid clears on a handshake unless a new column loads in the same cycle, in which case it stays high and the data is replaced.
- clr:
  - forces cnt to 0 and blocks acceptance that cycle (in_ready = 0 while clr = 1).
  - clr together with a pending output handshake: the handshake completes normally.
- Reset values: cnt = 0, mode_q = 0, collection register = 0, out_valid = 0, d0_out..d3_out = 8'h00. in_ready is 1 after reset.
- Reset asserted mid-column discards the partial column and any unconsumed output.

## Timing
- Latency: out_valid rises on the edge that accepts the last beat. The result is visible the cycle after that beat was presented.
- Throughput: one column per BEATS cycles, sustained, when out_ready is held high.
- With out_ready = 0 and out_valid = 1: the next column's non-last beats are still accepted; the last beat stalls (in_ready = 0) until out_ready rises. At most one complete column is buffered.
- Output data is stable while out_valid = 1 and out_ready = 0.
- No combinational path from d_in to the outputs. in_ready depends combinationally on out_ready, clr and cnt only.

## Configuration
- MIX_COLUMN_INV_EN
  - Defined: the inverse multiply network and mode_q are built, and inv selects the mode as above.
  - Undefined: forward only; inv is ignored (left unconnected internally), mode_q and the 9/11/13/14 multipliers are not synthesised, saving area for encrypt-only builds.

## Structure
- Shared package aes_pkg holds:
  - the xtime function
  - gf_mul2, gf_mul3, gf_mul9, gf_mul11, gf_mul13 and gf_mul14 functions
  - the reduction constant 8'h1B
  - typedef byte_t (logic [7:0]) and a col_t array of four byte_t
- One sub-module, mix_column_core: purely combinational; inputs col_t a and mode; output col_t o; contains the forward and optional inverse networks. The stream wrapper owns all registers, the counter and the handshake.

## Test plan
- IN_BYTES=1, inv=0, out_ready=1, beats db,13,53,45 -> one cycle after the last beat, out_valid=1 with d0..d3 = 8e,4d,a1,bc.
- IN_BYTES=4, back-to-back columns 455313db then 5c220af2, out_ready=1 -> consecutive outputs 8e,4d,a1,bc then 9f,dc,58,9d; in_ready stays 1.
- MIX_COLUMN_INV_EN defined, inv=1, IN_BYTES=2, beats 4d8e then bca1 -> d0..d3 = db,13,53,45. Toggling inv after the first beat gives the same result.
- Backpressure: out_ready=0 after the first column (8e..bc); send a second column f2,0a,22,5c -> the first three beats are accepted, in_ready=0 on the fourth, the outputs hold 8e,4d,a1,bc. Raise out_ready -> the second column (9f,dc,58,9d) loads on the same edge that the first is consumed.
- clr after two beats (db,13), then send f2,0a,22,5c -> output 9f,dc,58,9d; no corrupted column appears.
- Assert rst mid-column and while out_valid=1 -> out_valid=0, all outputs 00, cnt restarts at 0; the next full column computes correctly.
